// File: rtl/loader_pkg.sv
// Shared types for the boot-time program loader: frame FSM states, UART receiver states
// and the frame sync byte.
package loader_pkg;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SyncByte = 8'hA5;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, false-start rejection,
// one-cycle rxValid / rxFrameErr pulses at the stop-bit sample.
module uart_rx
  import loader_pkg::*;
#(
  parameter int ClksPerBit = 434
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       rx,
  output logic       rxValid,
  output logic       rxFrameErr,
  output logic [7:0] rxData
);

  localparam int CntW = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] HalfLast = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(ClksPerBit - 1);

  rx_state_t       state_q, state_d;
  logic [1:0]      sync_q;
  logic            prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            rx_s;

  assign rx_s = sync_q[1];

  // NOTE: sequential state uses non-blocking assignments only; the synchroniser resets to
  // the idle-high line level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FullLast) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FullLast) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = rx_s;
          ferr_d  = !rx_s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rxValid    = valid_q;
  assign rxFrameErr = ferr_q;
  assign rxData     = shift_q;

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses A5/LEN/data/CHK frames from the UART and writes big-endian 16-bit words
// into instruction memory, holding the CPU in reset until a frame verifies.
module program_loader
  import loader_pkg::*;
#(
  parameter int ClksPerBit = 434,
  parameter int AddrWidth  = 16,
  parameter int Depth      = 8192
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 uartRx,
  output logic                 imemWriteEnable,
  output logic [AddrWidth-1:0] imemWriteAddr,
  output logic [15:0]          imemWriteData,
  output logic                 cpuHold,
  output logic                 loadDone,
  output logic                 loadError,
  output logic [AddrWidth-1:0] wordCount
);

  localparam logic [16:0] DepthLimit = 17'(Depth);

  logic       rx_valid;
  logic       rx_frame_err;
  logic [7:0] rx_data;

  uart_rx #(.ClksPerBit(ClksPerBit)) u_uart_rx (
    .clk       (clk),
    .rstN      (rstN),
    .rx        (uartRx),
    .rxValid   (rx_valid),
    .rxFrameErr(rx_frame_err),
    .rxData    (rx_data)
  );

  loader_state_t        state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [7:0]           hi_q, hi_d;
  logic [7:0]           chk_q, chk_d;
  logic [AddrWidth-1:0] word_q, word_d;
  logic [AddrWidth-1:0] word_inc;
  logic [15:0]          data_q, data_d;
  logic [15:0]          new_len;
  logic                 we_q, we_d;
  logic                 done_q, err_q, hold_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= WAIT_SYNC;
      len_q   <= '0;
      hi_q    <= '0;
      chk_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      chk_q   <= chk_d;
      word_q  <= word_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= (state_d == DONE);
      err_q   <= (state_d == ERROR);
      hold_q  <= (state_d != DONE);
    end
  end

  assign word_inc = word_q + 1'b1;
  assign new_len  = {len_q[15:8], rx_data};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    chk_d   = chk_q;
    word_d  = word_q;
    data_d  = data_q;
    we_d    = 1'b0;
    unique case (state_q)
      WAIT_SYNC, DONE, ERROR: begin
        if (rx_valid && rx_data == SyncByte) begin
          state_d = LEN_HI;
          chk_d   = '0;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          len_d[15:8] = rx_data;
          chk_d       = chk_q ^ rx_data;
          state_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (rx_valid) begin
          len_d = new_len;
          chk_d = chk_q ^ rx_data;
          if ({1'b0, new_len} > DepthLimit) begin
            state_d = ERROR;
          end else begin
            word_d  = '0;
            state_d = (new_len == 16'd0) ? CHECK : DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        // The strobe cycle is followed by the address bump, so a strobe never repeats.
        if (we_q) begin
          word_d  = word_inc;
          state_d = (32'(word_inc) == 32'(len_q)) ? CHECK : DATA_HI;
        end else if (rx_valid) begin
          we_d   = 1'b1;
          data_d = {hi_q, rx_data};
          chk_d  = chk_q ^ rx_data;
        end
      end
      CHECK: begin
        if (rx_valid) state_d = (rx_data == chk_q) ? DONE : ERROR;
      end
      default: state_d = WAIT_SYNC;
    endcase

    if (rx_frame_err && !(state_q inside {WAIT_SYNC, DONE, ERROR})) begin
      state_d = ERROR;
      we_d    = 1'b0;
    end
  end

  assign imemWriteEnable = we_q;
  assign imemWriteAddr   = word_q;
  assign imemWriteData   = data_q;
  assign cpuHold         = hold_q;
  assign loadDone        = done_q;
  assign loadError       = err_q;
  assign wordCount       = word_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: behavioural 8N1 driver at 4 clocks/bit, write-port
// monitor, and hand-computed expectations for each frame scenario.
module tb_program_loader;

  localparam int Cpb = 4;
  localparam int AW  = 16;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          uartRx = 1'b1;
  logic          imemWriteEnable;
  logic [AW-1:0] imemWriteAddr;
  logic [15:0]   imemWriteData;
  logic          cpuHold;
  logic          loadDone;
  logic          loadError;
  logic [AW-1:0] wordCount;

  program_loader #(.ClksPerBit(Cpb), .AddrWidth(AW), .Depth(8192)) dut (
    .clk            (clk),
    .rstN           (rstN),
    .uartRx         (uartRx),
    .imemWriteEnable(imemWriteEnable),
    .imemWriteAddr  (imemWriteAddr),
    .imemWriteData  (imemWriteData),
    .cpuHold        (cpuHold),
    .loadDone       (loadDone),
    .loadError      (loadError),
    .wordCount      (wordCount)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write-port monitor: logs every strobe and counts strobes on back-to-back cycles.
  logic [AW-1:0] wr_addr[$];
  logic [15:0]   wr_data[$];
  int            back_to_back = 0;
  int            rx_count = 0;
  logic          we_prev = 1'b0;

  always @(negedge clk) begin
    if (imemWriteEnable === 1'b1) begin
      wr_addr.push_back(imemWriteAddr);
      wr_data.push_back(imemWriteData);
      if (we_prev) back_to_back++;
    end
    we_prev = (imemWriteEnable === 1'b1);
    if (dut.rx_valid === 1'b1) rx_count++;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uartRx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uartRx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    uartRx = stop_bit;
    repeat (Cpb) @(negedge clk);
    uartRx = 1'b1;
    repeat (2 * Cpb) @(negedge clk);
  endtask

  task automatic send_frame(input byte_q_t f);
    foreach (f[i]) send_byte(f[i], 1'b1);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_two_writes(input string tag, input int base, input logic [15:0] w0,
                                  input logic [15:0] w1);
    check({tag, "_nwr"}, wr_addr.size() - base, 2);
    if (wr_addr.size() - base >= 2) begin
      check({tag, "_a0"}, wr_addr[base], 0);
      check({tag, "_d0"}, wr_data[base], w0);
      check({tag, "_a1"}, wr_addr[base+1], 1);
      check({tag, "_d1"}, wr_data[base+1], w1);
    end
  endtask

  byte_q_t frame1, frame_badchk, frame_long, frame_empty, frame1_head;
  int base;
  int rx_base;

  initial begin
    // Checksum of 00 02 C0 01 C8 22 is 0x29.
    frame1       = '{8'hA5, 8'h00, 8'h02, 8'hC0, 8'h01, 8'hC8, 8'h22, 8'h29};
    frame_badchk = '{8'hA5, 8'h00, 8'h02, 8'hC0, 8'h01, 8'hC8, 8'h22, 8'h00};
    frame_long   = '{8'hA5, 8'h20, 8'h01};
    frame_empty  = '{8'hA5, 8'h00, 8'h00, 8'h00};
    frame1_head  = '{8'hA5, 8'h00, 8'h02, 8'hC0, 8'h01};

    repeat (3) @(negedge clk);
    check("rst_hold", cpuHold, 1);
    check("rst_done", loadDone, 0);
    check("rst_err", loadError, 0);
    check("rst_we", imemWriteEnable, 0);
    check("rst_wc", wordCount, 0);
    rstN = 1'b1;
    repeat (4) @(negedge clk);

    // 1: valid two-word frame
    base = wr_addr.size();
    send_frame(frame1);
    check_two_writes("t1", base, 16'hC001, 16'hC822);
    check("t1_done", loadDone, 1);
    check("t1_hold", cpuHold, 0);
    check("t1_err", loadError, 0);
    check("t1_wc", wordCount, 2);

    // 2: checksum mismatch after both writes
    base = wr_addr.size();
    send_frame(frame_badchk);
    check_two_writes("t2", base, 16'hC001, 16'hC822);
    check("t2_err", loadError, 1);
    check("t2_hold", cpuHold, 1);
    check("t2_done", loadDone, 0);

    // 3: over-length frame, then an empty valid frame
    base = wr_addr.size();
    send_frame(frame_long);
    check("t3_err", loadError, 1);
    check("t3_hold", cpuHold, 1);
    check("t3_nwr", wr_addr.size() - base, 0);
    send_frame(frame_empty);
    check("t3_err_clr", loadError, 0);
    check("t3_done", loadDone, 1);
    check("t3_hold_rel", cpuHold, 0);
    check("t3_wc", wordCount, 0);

    // 4: junk bytes and a one-cycle glitch before a valid frame
    base    = wr_addr.size();
    rx_base = rx_count;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    @(negedge clk);
    uartRx = 1'b0;
    @(negedge clk);
    uartRx = 1'b1;
    repeat (12) @(negedge clk);
    send_frame(frame1);
    check("t4_nbytes", rx_count - rx_base, 10);
    check_two_writes("t4", base, 16'hC001, 16'hC822);
    check("t4_done", loadDone, 1);
    check("t4_wc", wordCount, 2);

    // 5: reset mid-frame after the first word is written
    foreach (frame1_head[i]) send_byte(frame1_head[i], 1'b1);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    check("t5_hold", cpuHold, 1);
    check("t5_done", loadDone, 0);
    check("t5_err", loadError, 0);
    check("t5_we", imemWriteEnable, 0);
    check("t5_addr", imemWriteAddr, 0);
    check("t5_data", imemWriteData, 0);
    check("t5_wc", wordCount, 0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (4) @(negedge clk);
    base = wr_addr.size();
    send_frame(frame1);
    check_two_writes("t5", base, 16'hC001, 16'hC822);
    check("t5_done2", loadDone, 1);
    check("t5_hold2", cpuHold, 0);

    // 6: framing error on a data byte, then stray byte and restart after DONE
    foreach (frame1_head[i]) send_byte(frame1_head[i], 1'b1);
    send_byte(8'hC8, 1'b0);
    repeat (4) @(negedge clk);
    check("t6_err", loadError, 1);
    check("t6_hold", cpuHold, 1);
    send_frame(frame1);
    check("t6_done", loadDone, 1);
    send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    check("t6_stray_done", loadDone, 1);
    check("t6_stray_hold", cpuHold, 0);
    send_byte(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    check("t6_sync_hold", cpuHold, 1);
    check("t6_sync_done", loadDone, 0);

    check("strobe_b2b", back_to_back, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
